mem_access_ctrl: RTL and testbench

Synchronous load/store sequencer between the CPU datapath and the byte-addressed, big-endian 128-byte RAM.
- Accepts one load/store request via valid/ready and drives the RAM's enable, w_r, access_mode, address and data.
- Waits for the RAM's MOC completion flag, then returns size-adjusted, sign- or zero-extended load data with a one-cycle response pulse.
- Converts the RAM's asynchronous, level-style handshake into a clean clocked protocol for the pipeline.

---
 rtl/mem_access_ctrl_if.sv | 24 ++
 rtl/mem_access_ctrl.sv | 140 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// CPU-side load/store request and response bus for mem_access_ctrl.
// master = datapath issuing requests, slave = the controller.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_load, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_load, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the CPU datapath and the big-endian byte RAM.
// Define ALIGN_CHECK_EN to reject misaligned halfword/word accesses.
//
// state   | meaning
// IDLE    | req_ready high, waiting for a request
// WAIT    | ram_enable high, waiting for ram_moc or timeout
// DONE    | one-cycle response pulse
// RECOVER | waiting for ram_moc to fall before the next access
module mem_access_ctrl #(
  parameter int ADDR_WIDTH     = 7,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_access_ctrl_if.slave      bus,
  output logic                  ram_enable,
  output logic                  ram_w_r,
  output logic [1:0]            ram_access_mode,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [31:0]           ram_data,
  input  logic                  ram_moc,
  input  logic [31:0]           ram_mem
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, RECOVER} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          load_q;
  logic          signed_q;
  logic [1:0]    nbytes_m1;
  logic [32:0]   last_addr;
  logic          req_err;

  function automatic logic [31:0] extend(input logic [1:0] size, input logic sgn,
                                         input logic [31:0] d);
    case (size)
      2'b00:   extend = {{24{sgn & d[7]}}, d[7:0]};
      2'b01:   extend = {{16{sgn & d[15]}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  // Range check uses the last byte touched so a wide access cannot run off the top.
  always_comb begin
    nbytes_m1 = 2'd0;
    case (bus.req_size)
      2'b01:   nbytes_m1 = 2'd1;
      2'b10:   nbytes_m1 = 2'd3;
      default: nbytes_m1 = 2'd0;
    endcase
    last_addr = {1'b0, bus.req_addr} + {31'b0, nbytes_m1};
    req_err   = (bus.req_size == 2'b11) ||
                (|bus.req_addr[31:ADDR_WIDTH]) ||
                (|last_addr[32:ADDR_WIDTH]);
`ifdef ALIGN_CHECK_EN
    if ((bus.req_size == 2'b01 && bus.req_addr[0]) ||
        (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00))
      req_err = 1'b1;
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      load_q          <= 1'b0;
      signed_q        <= 1'b0;
      bus.req_ready   <= 1'b1;
      bus.resp_valid  <= 1'b0;
      bus.resp_err    <= 1'b0;
      bus.resp_rdata  <= '0;
      ram_enable      <= 1'b0;
      ram_w_r         <= 1'b1;
      ram_access_mode <= 2'b00;
      ram_address     <= '0;
      ram_data        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            load_q          <= bus.req_load;
            signed_q        <= bus.req_signed;
            ram_access_mode <= bus.req_size;
            ram_address     <= bus.req_addr[ADDR_WIDTH-1:0];
            ram_data        <= bus.req_wdata;
            cnt             <= '0;
            bus.req_ready   <= 1'b0;
            if (req_err) begin
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
              state          <= DONE;
            end else begin
              ram_enable <= 1'b1;
              ram_w_r    <= bus.req_load;
              state      <= WAIT;
            end
          end
        end
        WAIT: begin
          // MOC is checked first so a completion on the timeout edge is not an error.
          if (ram_moc) begin
            ram_enable     <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= load_q ? extend(ram_access_mode, signed_q, ram_mem) : '0;
            state          <= DONE;
          end else if (cnt == CNT_LAST) begin
            ram_enable     <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b1;
            bus.resp_rdata <= '0;
            state          <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          bus.resp_valid <= 1'b0;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= '0;
          state          <= RECOVER;
        end
        RECOVER: begin
          if (!ram_moc) begin
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a behavioural big-endian RAM.
module tb_mem_access_ctrl;
  localparam int AW = 7;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ram_enable, ram_w_r;
  logic [1:0]    ram_access_mode;
  logic [AW-1:0] ram_address;
  logic [31:0]   ram_data;
  logic          ram_moc = 1'b0;
  logic [31:0]   ram_mem = '0;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [0:127];
  logic       no_moc = 1'b0;
  int         dly = 0;
  int         rises = 0;
  logic       en_prev = 1'b0;
  int         accepts = 0;

  always #5 clk = ~clk;

  mem_access_ctrl_if bus();

  mem_access_ctrl #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .ram_enable(ram_enable), .ram_w_r(ram_w_r), .ram_access_mode(ram_access_mode),
    .ram_address(ram_address), .ram_data(ram_data), .ram_moc(ram_moc), .ram_mem(ram_mem)
  );

  // RAM model: completes two cycles after enable, holds MOC until enable falls.
  always @(posedge clk) begin
    if (!ram_enable) begin
      ram_moc <= 1'b0;
      dly = 0;
    end else if (!ram_moc && !no_moc) begin
      if (dly < 2) dly = dly + 1;
      else begin
        if (ram_w_r) begin
          case (ram_access_mode)
            2'b00:   ram_mem <= {24'h0, mem[ram_address]};
            2'b01:   ram_mem <= {16'h0, mem[ram_address], mem[7'(ram_address + 1)]};
            default: ram_mem <= {mem[ram_address], mem[7'(ram_address + 1)],
                                 mem[7'(ram_address + 2)], mem[7'(ram_address + 3)]};
          endcase
        end else begin
          case (ram_access_mode)
            2'b00: mem[ram_address] = ram_data[7:0];
            2'b01: begin
              mem[ram_address]           = ram_data[15:8];
              mem[7'(ram_address + 1)]   = ram_data[7:0];
            end
            default: begin
              mem[ram_address]           = ram_data[31:24];
              mem[7'(ram_address + 1)]   = ram_data[23:16];
              mem[7'(ram_address + 2)]   = ram_data[15:8];
              mem[7'(ram_address + 3)]   = ram_data[7:0];
            end
          endcase
        end
        ram_moc <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (ram_enable && !en_prev) rises = rises + 1;
    en_prev = ram_enable;
  end

  always @(posedge clk)
    if (!reset && bus.req_valid && bus.req_ready) accepts = accepts + 1;

  task automatic drive_req(input logic ld, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd);
    bus.req_load   = ld;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
  endtask

  task automatic wait_ready(input string name);
    bit got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = bus.req_ready;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL %s: req_ready never rose (timeout)", name);
    end
  endtask

  task automatic do_access(input string name, input logic ld, input logic [1:0] sz,
                           input logic sg, input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rdata, output logic err, output int cyc,
                           output int nrise, output logic rdy_at, output logic en_at);
    int r0;
    bit got = 0;
    rdata = 'x; err = 1'bx; cyc = 0; rdy_at = 1'bx; en_at = 1'bx;
    wait_ready(name);
    r0 = rises;
    drive_req(ld, sz, sg, a, wd);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    while (!got && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (bus.resp_valid) begin
        got = 1; rdata = bus.resp_rdata; err = bus.resp_err;
        rdy_at = bus.req_ready; en_at = ram_enable;
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL %s: no resp_valid within 64 cycles", name);
    end
    nrise = rises - r0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 ||
        bus.resp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus: ready=%b valid=%b err=%b rdata=%h, want 1 0 0 00000000",
               bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata);
    end
    checks++;
    if (ram_enable !== 1'b0 || ram_w_r !== 1'b1 || ram_access_mode !== 2'b00 ||
        ram_address !== 7'h0 || ram_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_ram: en=%b w_r=%b mode=%b addr=%h data=%h, want 0 1 00 00 00000000",
               ram_enable, ram_w_r, ram_access_mode, ram_address, ram_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_load_byte();
    logic [31:0] rd; logic er, ra, ea; int cy, nr;
    mem[5] = 8'h80;
    do_access("ldb_s", 1, 2'b00, 1, 32'd5, 32'h0, rd, er, cy, nr, ra, ea);
    checks++;
    if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin
      failures++; $display("FAIL ldb_s: rdata=%h err=%b, want FFFFFF80 0", rd, er);
    end
    checks++;
    if (ra !== 1'b0) begin
      failures++; $display("FAIL ldb_s_ready: req_ready=%b during resp_valid, want 0", ra);
    end
    do_access("ldb_u", 1, 2'b00, 0, 32'd5, 32'h0, rd, er, cy, nr, ra, ea);
    checks++;
    if (rd !== 32'h00000080 || er !== 1'b0) begin
      failures++; $display("FAIL ldb_u: rdata=%h err=%b, want 00000080 0", rd, er);
    end
  endtask

  task automatic test_store_load_word();
    logic [31:0] rd; logic er, ra, ea; int cy, nr;
    do_access("stw", 0, 2'b10, 0, 32'd8, 32'hDEADBEEF, rd, er, cy, nr, ra, ea);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0 || nr != 1) begin
      failures++; $display("FAIL stw: rdata=%h err=%b rises=%0d, want 00000000 0 1", rd, er, nr);
    end
    checks++;
    if ({mem[8], mem[9], mem[10], mem[11]} !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL stw_bytes: bytes8..11=%h %h %h %h, want DE AD BE EF",
               mem[8], mem[9], mem[10], mem[11]);
    end
    do_access("ldw", 1, 2'b10, 0, 32'd8, 32'h0, rd, er, cy, nr, ra, ea);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || nr != 1) begin
      failures++; $display("FAIL ldw: rdata=%h err=%b rises=%0d, want DEADBEEF 0 1", rd, er, nr);
    end
  endtask

  task automatic test_halfword();
    logic [31:0] rd; logic er, ra, ea; int cy, nr;
    mem[20] = 8'h85; mem[21] = 8'h01;
    do_access("ldh_s", 1, 2'b01, 1, 32'd20, 32'h0, rd, er, cy, nr, ra, ea);
    checks++;
    if (rd !== 32'hFFFF8501 || er !== 1'b0) begin
      failures++; $display("FAIL ldh_s: rdata=%h err=%b, want FFFF8501 0", rd, er);
    end
    do_access("ldh_u", 1, 2'b01, 0, 32'd20, 32'h0, rd, er, cy, nr, ra, ea);
    checks++;
    if (rd !== 32'h00008501 || er !== 1'b0) begin
      failures++; $display("FAIL ldh_u: rdata=%h err=%b, want 00008501 0", rd, er);
    end
    do_access("stb", 0, 2'b00, 0, 32'd30, 32'h123456AB, rd, er, cy, nr, ra, ea);
    do_access("ldb30", 1, 2'b00, 1, 32'd30, 32'h0, rd, er, cy, nr, ra, ea);
    checks++;
    if (rd !== 32'hFFFFFFAB || er !== 1'b0 || mem[31] !== 8'h00) begin
      failures++;
      $display("FAIL stb_ldb: rdata=%h err=%b byte31=%h, want FFFFFFAB 0 00", rd, er, mem[31]);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic er, ra, ea; int cy, nr;
    mem[3] = 8'h12; mem[4] = 8'h34;
    do_access("ldh_mis", 1, 2'b01, 0, 32'd3, 32'h0, rd, er, cy, nr, ra, ea);
    checks++;
`ifdef ALIGN_CHECK_EN
    if (rd !== 32'h0 || er !== 1'b1 || nr != 0) begin
      failures++; $display("FAIL ldh_mis: rdata=%h err=%b rises=%0d, want 00000000 1 0", rd, er, nr);
    end
`else
    if (rd !== 32'h00001234 || er !== 1'b0 || nr != 1) begin
      failures++; $display("FAIL ldh_mis: rdata=%h err=%b rises=%0d, want 00001234 0 1", rd, er, nr);
    end
`endif
  endtask

  task automatic test_range();
    logic [31:0] rd; logic er, ra, ea; int cy, nr;
    mem[124] = 8'h01; mem[125] = 8'h02; mem[126] = 8'h03; mem[127] = 8'h04;
    do_access("ldw124", 1, 2'b10, 0, 32'd124, 32'h0, rd, er, cy, nr, ra, ea);
    checks++;
    if (rd !== 32'h01020304 || er !== 1'b0) begin
      failures++; $display("FAIL ldw124: rdata=%h err=%b, want 01020304 0", rd, er);
    end
    do_access("ldw126", 1, 2'b10, 0, 32'd126, 32'h0, rd, er, cy, nr, ra, ea);
    checks++;
    if (rd !== 32'h0 || er !== 1'b1 || nr != 0 || cy != 1) begin
      failures++;
      $display("FAIL ldw126: rdata=%h err=%b rises=%0d cyc=%0d, want 00000000 1 0 1", rd, er, nr, cy);
    end
    do_access("ldb127", 1, 2'b00, 0, 32'd127, 32'h0, rd, er, cy, nr, ra, ea);
    checks++;
    if (rd !== 32'h00000004 || er !== 1'b0) begin
      failures++; $display("FAIL ldb127: rdata=%h err=%b, want 00000004 0", rd, er);
    end
    do_access("ldb128", 1, 2'b00, 0, 32'd128, 32'h0, rd, er, cy, nr, ra, ea);
    checks++;
    if (rd !== 32'h0 || er !== 1'b1 || nr != 0) begin
      failures++; $display("FAIL ldb128: rdata=%h err=%b rises=%0d, want 00000000 1 0", rd, er, nr);
    end
    do_access("size11", 1, 2'b11, 0, 32'd0, 32'h0, rd, er, cy, nr, ra, ea);
    checks++;
    if (rd !== 32'h0 || er !== 1'b1 || nr != 0) begin
      failures++; $display("FAIL size11: rdata=%h err=%b rises=%0d, want 00000000 1 0", rd, er, nr);
    end
    do_access("stw126", 0, 2'b10, 0, 32'd126, 32'hCAFEF00D, rd, er, cy, nr, ra, ea);
    checks++;
    if (er !== 1'b1 || nr != 0 || mem[126] !== 8'h03) begin
      failures++;
      $display("FAIL stw126: err=%b rises=%0d byte126=%h, want 1 0 03", er, nr, mem[126]);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] rd; logic er, ra, ea; int cy, nr;
    no_moc = 1'b1;
    do_access("timeout", 1, 2'b10, 0, 32'd0, 32'h0, rd, er, cy, nr, ra, ea);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0 || cy != TO + 1) begin
      failures++;
      $display("FAIL timeout: err=%b rdata=%h cyc=%0d, want 1 00000000 %0d", er, rd, cy, TO + 1);
    end
    checks++;
    if (ea !== 1'b0 || nr != 1) begin
      failures++; $display("FAIL timeout_en: ram_enable=%b rises=%0d, want 0 1", ea, nr);
    end
    no_moc = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    int seen = 0;
    no_moc = 1'b1;
    wait_ready("rst_wait");
    drive_req(1, 2'b10, 0, 32'd0, 32'h0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ram_enable !== 1'b1) begin
      failures++; $display("FAIL rst_wait_pre: ram_enable=%b, want 1", ram_enable);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (ram_enable !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_wait: en=%b ready=%b resp_valid=%b, want 0 1 0",
               ram_enable, bus.req_ready, bus.resp_valid);
    end
    reset = 1'b0;
    no_moc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.resp_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL rst_wait_noresp: resp_valid seen %0d times, want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int r0, a0, nresp, cyc;
    logic [31:0] rd [2];
    logic ra [2];
    wait_ready("b2b");
    r0 = rises; a0 = accepts; nresp = 0; cyc = 0;
    drive_req(1, 2'b10, 0, 32'd8, 32'h0);
    while (nresp < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.resp_valid) begin
        rd[nresp] = bus.resp_rdata; ra[nresp] = bus.req_ready; nresp++;
      end
    end
    bus.req_valid = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (nresp != 2) begin
      failures++; $display("FAIL b2b_resp: responses=%0d, want 2", nresp);
    end else begin
      checks++;
      if (rd[0] !== 32'hDEADBEEF || rd[1] !== 32'hDEADBEEF || ra[0] !== 1'b0 || ra[1] !== 1'b0) begin
        failures++;
        $display("FAIL b2b_data: rdata=%h,%h ready=%b,%b, want DEADBEEF,DEADBEEF 0,0",
                 rd[0], rd[1], ra[0], ra[1]);
      end
    end
    checks++;
    if (accepts - a0 != 2 || rises - r0 != 2) begin
      failures++;
      $display("FAIL b2b_count: accepts=%0d rises=%0d, want 2 2", accepts - a0, rises - r0);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    bus.req_valid = 1'b0; bus.req_load = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    test_reset();
    test_load_byte();
    test_store_load_word();
    test_halfword();
    test_misaligned();
    test_range();
    test_timeout();
    test_reset_in_wait();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
